// File: rtl/lotr_pkg.sv
// lotr_pkg: shared opcode, MMIO arbiter constants and request struct
package lotr_pkg;
  typedef enum logic [1:0] {RD = 2'd0, WR = 2'd1, RD_RSP = 2'd2} t_opcode;
  localparam int MMIO_NUM_REQ = 4;
  localparam int MMIO_TAG_DEPTH = 4;
  typedef struct packed {
    logic valid;
    t_opcode opcode;
    logic [31:0] address;
    logic [31:0] data;
  } t_mmio_req;
endpackage

// File: rtl/fpga_mmio_arb_tag_fifo.sv
// fpga_mmio_arb_tag_fifo: in-order FIFO of requester ids for outstanding MMIO requests
module fpga_mmio_arb_tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  assign head = mem[rd_ptr];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
endmodule

// File: rtl/fpga_mmio_arb.sv
// fpga_mmio_arb: round-robin arbiter sharing one MMIO port with in-order response steering
module fpga_mmio_arb
  import lotr_pkg::*;
#(
  parameter int NUM_REQ = MMIO_NUM_REQ,
  parameter int TAG_DEPTH = MMIO_TAG_DEPTH
) (
  input  logic               CLK_50,
  input  logic               RstQnnnH,
  input  logic [NUM_REQ-1:0] Req_Valid,
  input  t_opcode            Req_Opcode [NUM_REQ],
  input  logic [31:0]        Req_Address [NUM_REQ],
  input  logic [31:0]        Req_Data [NUM_REQ],
  output logic [NUM_REQ-1:0] Req_Ready,
  output logic               Mmio_ReqValid,
  output t_opcode            Mmio_ReqOpcode,
  output logic [31:0]        Mmio_ReqAddress,
  output logic [31:0]        Mmio_ReqData,
  input  logic               Mmio_RspValid,
  input  t_opcode            Mmio_RspOpcode,
  input  logic [31:0]        Mmio_RspAddress,
  input  logic [31:0]        Mmio_RspData,
  output logic [NUM_REQ-1:0] Rsp_Valid,
  output t_opcode            Rsp_Opcode,
  output logic [31:0]        Rsp_Address,
  output logic [31:0]        Rsp_Data,
  output logic               ErrUnexpRsp
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  logic [IW-1:0] last_grant, gidx, idx, head;
  logic [CW-1:0] count;
  logic empty, full, pop, accept;
  t_mmio_req req_q;
  fpga_mmio_arb_tag_fifo #(.W(IW), .DEPTH(TAG_DEPTH)) u_fifo (
    .clk(CLK_50),
    .rst(RstQnnnH),
    .push(accept),
    .pop(pop),
    .din(gidx),
    .head(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  assign pop = Mmio_RspValid & (count != '0);
  assign accept = |Req_Valid & (~full | pop);
  always_comb begin
    gidx = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      gidx = Req_Valid[idx] ? idx : gidx;
    end
  end
  assign Req_Ready = accept ? NUM_REQ'(1) << gidx : '0;
  always_ff @(posedge CLK_50) begin
    if (RstQnnnH) begin
      req_q <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      Rsp_Valid <= '0;
      Rsp_Opcode <= RD;
      Rsp_Address <= '0;
      Rsp_Data <= '0;
      ErrUnexpRsp <= 1'b0;
    end else begin
      req_q.valid <= accept;
      if (accept) begin
        req_q.opcode <= Req_Opcode[gidx];
        req_q.address <= Req_Address[gidx];
        req_q.data <= Req_Data[gidx];
        last_grant <= gidx;
      end
      Rsp_Valid <= pop ? NUM_REQ'(1) << head : '0;
      if (pop) begin
        Rsp_Opcode <= Mmio_RspOpcode;
        Rsp_Address <= Mmio_RspAddress;
        Rsp_Data <= Mmio_RspData;
      end
      ErrUnexpRsp <= ErrUnexpRsp | (Mmio_RspValid & empty);
    end
  end
  assign Mmio_ReqValid = req_q.valid;
  assign Mmio_ReqOpcode = req_q.opcode;
  assign Mmio_ReqAddress = req_q.address;
  assign Mmio_ReqData = req_q.data;
endmodule

// File: tb/tb_fpga_mmio_arb.sv
// tb_fpga_mmio_arb: scoreboard bench with randomized requesters and a 3-cycle MMIO model
module tb_fpga_mmio_arb;
  import lotr_pkg::*;
  logic clk = 1'b0;
  logic RstQnnnH;
  logic [3:0] Req_Valid, Req_Ready, Rsp_Valid;
  t_opcode Req_Opcode [4];
  logic [31:0] Req_Address [4];
  logic [31:0] Req_Data [4];
  logic Mmio_ReqValid, Mmio_RspValid, ErrUnexpRsp;
  t_opcode Mmio_ReqOpcode, Mmio_RspOpcode, Rsp_Opcode;
  logic [31:0] Mmio_ReqAddress, Mmio_ReqData, Mmio_RspAddress, Mmio_RspData, Rsp_Address, Rsp_Data;
  fpga_mmio_arb dut (
    .CLK_50(clk),
    .RstQnnnH(RstQnnnH),
    .Req_Valid(Req_Valid),
    .Req_Opcode(Req_Opcode),
    .Req_Address(Req_Address),
    .Req_Data(Req_Data),
    .Req_Ready(Req_Ready),
    .Mmio_ReqValid(Mmio_ReqValid),
    .Mmio_ReqOpcode(Mmio_ReqOpcode),
    .Mmio_ReqAddress(Mmio_ReqAddress),
    .Mmio_ReqData(Mmio_ReqData),
    .Mmio_RspValid(Mmio_RspValid),
    .Mmio_RspOpcode(Mmio_RspOpcode),
    .Mmio_RspAddress(Mmio_RspAddress),
    .Mmio_RspData(Mmio_RspData),
    .Rsp_Valid(Rsp_Valid),
    .Rsp_Opcode(Rsp_Opcode),
    .Rsp_Address(Rsp_Address),
    .Rsp_Data(Rsp_Data),
    .ErrUnexpRsp(ErrUnexpRsp)
  );
  always #5 clk = ~clk;
  typedef struct {int due; t_opcode op; logic [31:0] a; logic [31:0] d;} mreq_t;
  typedef struct {int due; logic [3:0] oh; t_opcode op; logic [31:0] a; logic [31:0] d;} rsp_t;
  int vec = 0, errs = 0, cyc = 0, last = 3, err_cyc = 0;
  logic p_v [4];
  t_opcode p_op [4];
  logic [31:0] p_a [4], p_d [4];
  logic stall = 1'b0, inject = 1'b0, force_en = 1'b0;
  logic [31:0] force_val = '0;
  int ids [$];
  int gq [$];
  mreq_t exp_req [$];
  mreq_t mm_pend [$];
  rsp_t exp_rsp [$];
  logic [3:0] last_oh = '0;
  logic [31:0] last_data = '0;
  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
    end
  endtask
  task automatic refill(input int i, input t_opcode op);
    p_v[i] = 1'b1;
    p_op[i] = op;
    p_a[i] = $urandom;
    p_d[i] = $urandom;
  endtask
  task automatic clear_valid();
    for (int i = 0; i < 4; i++) p_v[i] = 1'b0;
  endtask
  task automatic step();
    mreq_t m;
    int id, g, idx;
    logic [3:0] exp_ready;
    @(posedge clk);
    #1;
    cyc++;
    RstQnnnH = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Req_Valid[i] = p_v[i];
      Req_Opcode[i] = p_op[i];
      Req_Address[i] = p_a[i];
      Req_Data[i] = p_d[i];
    end
    Mmio_RspValid = 1'b0;
    if (inject) begin
      Mmio_RspValid = 1'b1;
      Mmio_RspOpcode = RD_RSP;
      Mmio_RspAddress = $urandom;
      Mmio_RspData = $urandom;
    end else if (!stall && mm_pend.size() > 0 && mm_pend[0].due <= cyc) begin
      m = mm_pend.pop_front();
      Mmio_RspValid = 1'b1;
      Mmio_RspOpcode = m.op;
      Mmio_RspAddress = m.a;
      Mmio_RspData = m.d;
    end
    if (Mmio_RspValid && ids.size() == 0 && err_cyc == 0) err_cyc = cyc + 1;
    if (Mmio_RspValid && ids.size() > 0) begin
      id = ids.pop_front();
      exp_rsp.push_back('{cyc + 1, 4'b0001 << id, Mmio_RspOpcode, Mmio_RspAddress, Mmio_RspData});
    end
    g = -1;
    if (ids.size() < 4)
      for (int k = 1; k <= 4; k++) begin
        idx = (last + k) % 4;
        if (g < 0 && p_v[idx]) g = idx;
      end
    exp_ready = g < 0 ? 4'b0 : 4'b0001 << g;
    @(negedge clk);
    chk("req_ready", Req_Ready, exp_ready);
    if (g >= 0) begin
      exp_req.push_back('{cyc + 1, p_op[g], p_a[g], p_d[g]});
      ids.push_back(g);
      gq.push_back(g);
      last = g;
      p_v[g] = 1'b0;
    end
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    cyc++;
    RstQnnnH = 1'b1;
    Req_Valid = '0;
    Mmio_RspValid = 1'b0;
    inject = 1'b0;
    clear_valid();
    ids.delete();
    exp_req.delete();
    exp_rsp.delete();
    mm_pend.delete();
    last = 3;
    err_cyc = 0;
    @(posedge clk);
    #1;
    cyc++;
    RstQnnnH = 1'b0;
    @(negedge clk);
    chk("rst_mmio_valid", Mmio_ReqValid, 0);
    chk("rst_mmio_payload", {Mmio_ReqOpcode, Mmio_ReqAddress, Mmio_ReqData}, 0);
    chk("rst_rsp_valid", Rsp_Valid, 0);
    chk("rst_rsp_payload", {Rsp_Opcode, Rsp_Address, Rsp_Data}, 0);
    chk("rst_err", ErrUnexpRsp, 0);
    chk("rst_ready_idle", Req_Ready, 0);
  endtask
  mreq_t mm;
  rsp_t rr;
  logic ev, eo;
  always @(negedge clk) begin
    if (!RstQnnnH) begin
      ev = exp_req.size() > 0 && exp_req[0].due <= cyc;
      chk("mmio_req_valid", Mmio_ReqValid, ev);
      if (ev) begin
        mm = exp_req.pop_front();
        chk("mmio_req_payload", {Mmio_ReqOpcode, Mmio_ReqAddress, Mmio_ReqData}, {mm.op, mm.a, mm.d});
        mm_pend.push_back('{cyc + 3, RD_RSP, mm.a, mm.op == WR ? mm.d : (force_en ? force_val : $urandom)});
      end
      eo = exp_rsp.size() > 0 && exp_rsp[0].due <= cyc;
      chk("rsp_valid", Rsp_Valid, eo ? exp_rsp[0].oh : 4'b0);
      if (eo) begin
        rr = exp_rsp.pop_front();
        chk("rsp_payload", {Rsp_Opcode, Rsp_Address, Rsp_Data}, {rr.op, rr.a, rr.d});
      end
      if (Rsp_Valid != 0) begin
        last_oh = Rsp_Valid;
        last_data = Rsp_Data;
      end
      chk("err_flag", ErrUnexpRsp, err_cyc != 0 && cyc >= err_cyc);
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int n0, c0, lim;
    RstQnnnH = 1'b1;
    Req_Valid = '0;
    Mmio_RspValid = 1'b0;
    Mmio_RspOpcode = RD_RSP;
    Mmio_RspAddress = '0;
    Mmio_RspData = '0;
    for (int i = 0; i < 4; i++) begin
      p_v[i] = 1'b0;
      p_op[i] = RD;
      p_a[i] = '0;
      p_d[i] = '0;
      Req_Opcode[i] = RD;
      Req_Address[i] = '0;
      Req_Data[i] = '0;
    end
    do_reset();
    p_v[2] = 1'b1;
    p_op[2] = RD;
    p_a[2] = 32'h0000_1000;
    p_d[2] = '0;
    force_en = 1'b1;
    force_val = 32'h3FF;
    repeat (7) step();
    force_en = 1'b0;
    chk("single_rsp", {last_oh, last_data}, {4'b0100, 32'h3FF});
    do_reset();
    gq.delete();
    for (int i = 0; i < 4; i++) refill(i, RD);
    lim = 0;
    while (gq.size() < 8 && lim < 50) begin
      step();
      lim++;
      for (int i = 0; i < 4; i++) if (!p_v[i]) refill(i, (i % 2) ? WR : RD);
    end
    for (int k = 0; k < 8; k++) chk("rr_order", k < gq.size() ? gq[k] : -1, k % 4);
    clear_valid();
    repeat (8) step();
    n0 = gq.size();
    c0 = cyc;
    lim = 0;
    while (gq.size() - n0 < 10 && lim < 50) begin
      if (!p_v[1]) refill(1, WR);
      step();
      lim++;
    end
    chk("b2b_cycles", cyc - c0, 10);
    clear_valid();
    repeat (8) step();
    stall = 1'b1;
    n0 = gq.size();
    for (int i = 0; i < 4; i++) refill(i, RD);
    repeat (6) begin
      step();
      for (int i = 0; i < 4; i++) if (!p_v[i]) refill(i, WR);
    end
    chk("stall_accepts", gq.size() - n0, 4);
    chk("stall_ready", Req_Ready, 0);
    stall = 1'b0;
    n0 = gq.size();
    step();
    chk("release_grant", gq.size() - n0, 1);
    clear_valid();
    repeat (10) step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    chk("err_sticky", ErrUnexpRsp, 1);
    do_reset();
    n0 = gq.size();
    lim = 0;
    while (gq.size() - n0 < 3 && lim < 20) begin
      if (!p_v[3]) refill(3, RD);
      step();
      lim++;
    end
    do_reset();
    for (int i = 0; i < 4; i++) refill(i, WR);
    step();
    chk("post_reset_grant", gq[gq.size() - 1], 0);
    clear_valid();
    repeat (10) step();
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if (p_v[i] && $urandom_range(0, 15) == 0) p_v[i] = 1'b0;
        else if (!p_v[i] && $urandom_range(0, 2) == 0) refill(i, $urandom_range(0, 1) ? WR : RD);
      end
      stall = $urandom_range(0, 4) == 0;
      step();
    end
    stall = 1'b0;
    clear_valid();
    repeat (20) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
